// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 instruction word encoder with one output register, address counter and error count
// Optional build macro: IMM_RANGE_CHECK_EN (flags immediates that do not fit their instruction field)
`timescale 1ns/1ps

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef OP_R_TYPE
`define OP_R_TYPE   7'b0110011
`endif
`ifndef OP_I_TYPE
`define OP_I_TYPE   7'b0010011
`endif
`ifndef OP_I_L_TYPE
`define OP_I_L_TYPE 7'b0000011
`endif
`ifndef OP_S_TYPE
`define OP_S_TYPE   7'b0100011
`endif
`ifndef OP_B_TYPE
`define OP_B_TYPE   7'b1100011
`endif
`ifndef OP_LUI
`define OP_LUI      7'b0110111
`endif
`ifndef OP_AUIPC
`define OP_AUIPC    7'b0010111
`endif

module instr_encoder (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [6:0]              i_opcode,
   input  logic [4:0]              i_rd,
   input  logic [4:0]              i_rs1,
   input  logic [4:0]              i_rs2,
   input  logic [2:0]              i_funct3,
   input  logic [6:0]              i_funct7,
   input  logic [`WORD_SIZE-1:0]   i_imm,
   input  logic                    i_clear,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [`WORD_SIZE-1:0]   o_instruction,
   output logic [`WORD_SIZE-1:0]   o_addr,
   output logic                    o_err,
   output logic [7:0]              o_err_cnt
);

   // Canonical NOP (addi x0, x0, 0) emitted in place of an unencodable request
   localparam logic [`WORD_SIZE-1:0] NOP_WORD = 32'h0000_0013;
   localparam logic [`WORD_SIZE-1:0] ADDR_STEP = 32'd4;

   logic                  accept;
   logic [`WORD_SIZE-1:0] next_addr;
   logic [`WORD_SIZE-1:0] addr_base;
   logic [7:0]            cnt_base;
   logic                  cnt_inc;
   logic [`WORD_SIZE-1:0] enc_word;
   logic                  enc_err;
   logic                  range_bad;

   // Single output register: ready whenever it is empty or being drained this cycle
   assign o_ready = i_rst_n && (!o_valid || i_ready);
   assign accept  = i_valid && o_ready;

`ifdef IMM_RANGE_CHECK_EN
   logic imm12_fits;
   logic imm20_fits;

   // An immediate fits when every bit above the field's sign bit copies that sign bit
   assign imm12_fits = (&i_imm[31:11]) || !(|i_imm[31:11]);
   assign imm20_fits = (&i_imm[31:19]) || !(|i_imm[31:19]);
`else
   logic unused_imm_hi;

   // Upper immediate bits only matter to the range check, which is compiled out here
   assign unused_imm_hi = ^i_imm[31:20];
`endif

   // Field packing per instruction format; unknown opcodes become a flagged NOP
   always_comb begin
      enc_word  = NOP_WORD;
      enc_err   = 1'b0;
      range_bad = 1'b0;
      case (i_opcode)
         `OP_R_TYPE: begin
            enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
         end
         `OP_I_TYPE, `OP_I_L_TYPE: begin
            enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
`ifdef IMM_RANGE_CHECK_EN
            range_bad = !imm12_fits;
`endif
         end
         `OP_S_TYPE: begin
            enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
`ifdef IMM_RANGE_CHECK_EN
            range_bad = !imm12_fits;
`endif
         end
         `OP_B_TYPE: begin
            // Branch immediate is kept unscaled: bit 11 on top, bit 10 tucked into [7]
            enc_word = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3,
                        i_imm[3:0], i_imm[10], i_opcode};
`ifdef IMM_RANGE_CHECK_EN
            range_bad = !imm12_fits;
`endif
         end
         `OP_LUI, `OP_AUIPC: begin
            enc_word = {i_imm[19:0], i_rd, i_opcode};
`ifdef IMM_RANGE_CHECK_EN
            range_bad = !imm20_fits;
`endif
         end
         default: begin
            enc_word = NOP_WORD;
            enc_err  = 1'b1;
         end
      endcase
      enc_err = enc_err || range_bad;
   end

   // Clear takes effect before the accepted word picks up its address and error count
   always_comb begin
      addr_base = i_clear ? '0 : next_addr;
      cnt_base  = i_clear ? 8'd0 : o_err_cnt;
      cnt_inc   = accept && enc_err && (cnt_base != 8'hFF);
   end

   // Output register, address counter and saturating error counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid       <= 1'b0;
         o_instruction <= '0;
         o_addr        <= '0;
         o_err         <= 1'b0;
         o_err_cnt     <= 8'd0;
         next_addr     <= '0;
      end else begin
         if (accept) begin
            o_valid       <= 1'b1;
            o_instruction <= enc_word;
            o_err         <= enc_err;
            o_addr        <= addr_base;
            next_addr     <= addr_base + ADDR_STEP;
         end else begin
            if (o_valid && i_ready) begin
               o_valid <= 1'b0;
            end
            next_addr <= addr_base;
         end
         o_err_cnt <= cnt_inc ? cnt_base + 8'd1 : cnt_base;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with scoreboard and immediate-generator model
`timescale 1ns/1ps

module tb_instr_encoder;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_IL  = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [6:0]  i_opcode = '0;
   logic [4:0]  i_rd = '0;
   logic [4:0]  i_rs1 = '0;
   logic [4:0]  i_rs2 = '0;
   logic [2:0]  i_funct3 = '0;
   logic [6:0]  i_funct7 = '0;
   logic [31:0] i_imm = '0;
   logic        i_clear = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_instruction;
   logic [31:0] o_addr;
   logic        o_err;
   logic [7:0]  o_err_cnt;

   instr_encoder dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
      .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm), .i_clear(i_clear),
      .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction),
      .o_addr(o_addr), .o_err(o_err), .o_err_cnt(o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] word;
      logic [31:0] addr;
      logic [31:0] imm;
      logic        err;
      bit          rt;
   } exp_t;

   exp_t        q[$];
   int unsigned addr_m = 0;
   int          cnt_m = 0;
   bit          rnd_ready = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic bit known(input logic [6:0] op);
      return op inside {OP_R, OP_I, OP_IL, OP_S, OP_B, OP_LUI, OP_AUI};
   endfunction

   function automatic bit fits(input logic [6:0] op, input logic [31:0] imm);
      int s;
      s = $signed(imm);
      if (op == OP_LUI || op == OP_AUI) return (s >= -524288) && (s <= 524287);
      if (op inside {OP_I, OP_IL, OP_S, OP_B}) return (s >= -2048) && (s <= 2047);
      return 1'b1;
   endfunction

   // Expected word built with shifts and masks on plain integers
   function automatic logic [31:0] model_word(input int unsigned op, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned f3, input int unsigned f7,
                                              input int unsigned u);
      int unsigned w;
      int unsigned base;
      base = (rs1 << 15) | (f3 << 12);
      if (op == OP_R)
         w = (f7 << 25) | (rs2 << 20) | base | (rd << 7) | op;
      else if (op == OP_I || op == OP_IL)
         w = ((u & 32'hFFF) << 20) | base | (rd << 7) | op;
      else if (op == OP_S)
         w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | base | ((u & 31) << 7) | op;
      else if (op == OP_B)
         w = (((u >> 11) & 1) << 31) | (((u >> 4) & 63) << 25) | (rs2 << 20) | base
             | ((u & 15) << 8) | (((u >> 10) & 1) << 7) | op;
      else if (op == OP_LUI || op == OP_AUI)
         w = ((u & 32'hFFFFF) << 12) | (rd << 7) | op;
      else
         w = 32'h13;
      return w;
   endfunction

   // Immediate generator: recovers the sign-extended immediate from a word
   function automatic logic [31:0] imm_gen(input logic [31:0] w);
      int s;
      int v;
      logic [6:0] op;
      s  = $signed(w);
      op = w[6:0];
      v  = 0;
      if (op == OP_I || op == OP_IL)
         v = s >>> 20;
      else if (op == OP_S)
         v = ((s >>> 25) * 32) + int'((w >> 7) & 32'd31);
      else if (op == OP_B)
         v = (w[31] ? -2048 : 0) + int'(((w >> 7) & 32'd1) << 10)
             + int'(((w >> 25) & 32'd63) << 4) + int'((w >> 8) & 32'd15);
      else if (op == OP_LUI || op == OP_AUI)
         v = s >>> 12;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the negedge, update the model, advance to the next negedge
   task automatic step(output bit acc);
      exp_t e;
      logic err_now;
      if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("err_cnt", {24'd0, o_err_cnt}, cnt_m);
      chk("ready", {31'd0, o_ready}, {31'd0, (!o_valid || i_ready)});
      if (o_valid && i_ready) begin
         n_checks++;
         assert (q.size() != 0)
         else begin
            n_errors++;
            $error("FAIL unexpected_word: observed %h expected none", o_instruction);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("instr", o_instruction, e.word);
            chk("addr", o_addr, e.addr);
            chk("err", {31'd0, o_err}, {31'd0, e.err});
            if (e.rt) chk("roundtrip", imm_gen(o_instruction), e.imm);
         end
      end
      acc = i_valid && (!o_valid || i_ready);
      if (i_clear) begin
         addr_m = 0;
         cnt_m  = 0;
      end
      if (acc) begin
         err_now = !known(i_opcode);
`ifdef IMM_RANGE_CHECK_EN
         err_now = err_now || !fits(i_opcode, i_imm);
`endif
         e.word = model_word(i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm);
         e.addr = addr_m;
         e.imm  = i_imm;
         e.err  = err_now;
         e.rt   = known(i_opcode) && (i_opcode != OP_R) && fits(i_opcode, i_imm);
         q.push_back(e);
         addr_m = addr_m + 4;
         if (err_now && cnt_m < 255) cnt_m++;
      end
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input bit clr);
      bit acc;
      i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
      i_funct3 = f3; i_funct7 = f7; i_imm = imm;
      i_valid = 1'b1; i_clear = clr; acc = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) step(acc);
      n_checks++;
      assert (acc)
      else begin
         n_errors++;
         $error("FAIL send_timeout: observed not accepted expected accepted");
      end
      i_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 64 && (o_valid || q.size() != 0); k++) step(acc);
      chk("drained", {31'd0, o_valid}, 32'd0);
   endtask

   initial begin
      bit acc;
      logic [31:0] word_a;
      logic [31:0] rimm;
      logic [6:0]  rop;
      logic [6:0]  ops[8];
      ops = '{OP_R, OP_I, OP_IL, OP_S, OP_B, OP_LUI, OP_AUI, OP_BAD};

      // Reset state
      @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      chk("rst_instr", o_instruction, 32'd0);
      chk("rst_addr", o_addr, 32'd0);
      chk("rst_err", {31'd0, o_err}, 32'd0);
      chk("rst_cnt", {24'd0, o_err_cnt}, 32'd0);
      i_rst_n = 1'b1;

      // addi x1, x2, -1
      send(OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
      chk("i_valid", {31'd0, o_valid}, 32'd1);
      chk("i_word", o_instruction, 32'hFFF1_0093);
      chk("i_err", {31'd0, o_err}, 32'd0);
      chk("i_addr", o_addr, 32'd0);

      // sw x5, 8(x6)
      send(OP_S, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'd8, 1'b0);
      chk("s_word", o_instruction, 32'h0053_2423);
      chk("s_addr", o_addr, 32'd4);

      // lui x3, 0x12345 and its round trip
      send(OP_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_2345, 1'b0);
      chk("lui_word", o_instruction, 32'h1234_51B7);
      chk("lui_rt", imm_gen(o_instruction), 32'h0001_2345);
      drain();

      // Backpressure, with clear restarting addresses at 0
      i_ready = 1'b0;
      send(OP_R, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'd0, 1'b1);
      word_a = model_word(OP_R, 7, 8, 9, 5, 32, 0);
      chk("bp_first_addr", o_addr, 32'd0);
      i_opcode = OP_B; i_rs1 = 5'd1; i_rs2 = 5'd2; i_funct3 = 3'd1; i_imm = 32'hFFFF_FFF0;
      i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", {31'd0, o_ready}, 32'd0);
         chk("bp_hold_word", o_instruction, word_a);
         chk("bp_hold_addr", o_addr, 32'd0);
         step(acc);
         chk("bp_no_accept", {31'd0, acc}, 32'd0);
      end
      i_ready = 1'b1;
      step(acc);
      chk("bp_accept", {31'd0, acc}, 32'd1);
      chk("bp_second_addr", o_addr, 32'd4);
      i_valid = 1'b0;
      drain();

      // Immediate just outside the 12-bit range
      send(OP_I, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0);
      chk("rng_field", {20'd0, o_instruction[31:20]}, 32'h800);
`ifdef IMM_RANGE_CHECK_EN
      chk("rng_err", {31'd0, o_err}, 32'd1);
`else
      chk("rng_err", {31'd0, o_err}, 32'd0);
`endif

      // Unknown opcode
      send(OP_BAD, 5'd9, 5'd9, 5'd9, 3'd7, 7'd0, 32'd0, 1'b0);
      chk("bad_word", o_instruction, 32'h0000_0013);
      chk("bad_err", {31'd0, o_err}, 32'd1);
      drain();

      // Randomized requests against the scoreboard
      rnd_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         rop = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0)
            rimm = $urandom;
         else if (rop == OP_LUI || rop == OP_AUI)
            rimm = int'($urandom_range(0, 1048575)) - 524288;
         else
            rimm = int'($urandom_range(0, 4095)) - 2048;
         send(rop, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
              rimm, ($urandom_range(0, 19) == 0));
      end
      rnd_ready = 1'b0;
      drain();

      // Error count saturates at 255
      for (int n = 0; n < 260; n++) send(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
      chk("sat_cnt", {24'd0, o_err_cnt}, 32'd255);
      drain();

      // Reset in the middle of traffic with five errors counted
      send(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
      for (int n = 0; n < 4; n++) send(OP_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
      i_ready = 1'b0;
      chk("pre_rst_cnt", {24'd0, o_err_cnt}, 32'd5);
      chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("mid_rst_addr", o_addr, 32'd0);
      chk("mid_rst_cnt", {24'd0, o_err_cnt}, 32'd0);
      chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
      q.delete();
      addr_m = 0;
      cnt_m  = 0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      send(OP_AUI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 1'b0);
      chk("post_rst_addr", o_addr, 32'd0);
      chk("post_rst_word", o_instruction, 32'h0000_1117);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have i_valid, input, 1: encode request valid.
REQ-004 SHALL have o_ready, output, 1: request accepted when i_valid && o_ready.
REQ-005 SHALL have i_opcode, input, 7: opcode, one of `OP_R_TYPE, `OP_I_TYPE, `OP_I_L_TYPE, `OP_S_TYPE, `OP_B_TYPE, `OP_LUI, `OP_AUIPC.
REQ-006 SHALL have i_rd, i_rs1, i_rs2, input, 5 each: register indices.
REQ-007 SHALL have i_funct3, input, 3, and i_funct7, input, 7: function fields.
REQ-008 SHALL have i_imm, input, `WORD_SIZE: sign-extended immediate in the same form the immediate generator produces.
REQ-009 SHALL have i_clear, input, 1: synchronous clear of the address counter and error count.
REQ-010 SHALL have o_valid, output, 1, and i_ready, input, 1: output handshake; transfer on o_valid && i_ready.
REQ-011 SHALL have o_instruction, output, `WORD_SIZE: encoded instruction word.
REQ-012 SHALL have o_addr, output, `WORD_SIZE: byte address of the word on o_instruction.
REQ-013 SHALL have o_err, output, 1, and o_err_cnt, output, 8: per-word error flag and saturating error count.

Function
REQ-014 SHALL drive o_ready = !o_valid || i_ready: one output register, no bubble under continuous flow.
REQ-015 SHALL present an accepted request on o_valid/o_instruction in the cycle after acceptance (latency 1).
REQ-016 SHALL hold o_instruction, o_addr and o_err stable while o_valid && !i_ready.
REQ-017 SHALL place opcode at [6:0], rd at [11:7] (R, I, I_L, U), funct3 at [14:12] and rs1 at [19:15] (R, I, I_L, S, B), rs2 at [24:20] (R, S, B), funct7 at [31:25] (R).
REQ-018 SHALL place imm[11:0] at [31:20] for I and I_L.
REQ-019 SHALL place imm[11:5] at [31:25] and imm[4:0] at [11:7] for S.
REQ-020 SHALL map B as [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
REQ-021 SHALL place imm[19:0] at [31:12] for LUI and AUIPC.
REQ-022 SHALL guarantee that feeding o_instruction to the immediate generator returns i_imm for every in-range immediate.
REQ-023 SHALL, for an unknown opcode, emit 32'h00000013 with o_err=1.
REQ-024 SHALL keep an internal next-address register, start it at 0, assign it to o_addr at acceptance, and advance it by 4 per acceptance, wrapping modulo 2^32.
REQ-025 SHALL increment o_err_cnt once per accepted request whose o_err is 1, and saturate it at 255.
REQ-026 SHALL, on i_clear with a simultaneous acceptance, give that word address 0 and set the next address to 4; o_err_cnt becomes 0, or 1 if that word errs.

Reset
REQ-027 SHALL, while i_rst_n is low, force o_valid=0, o_instruction=0, o_addr=0, o_err=0, o_err_cnt=0, next address=0 and o_ready=0, independent of i_clk.
REQ-028 SHALL discard any in-flight word on reset assertion mid-operation and resume accepting on the first edge after deassertion.

Configuration
REQ-029 SHALL support the macro IMM_RANGE_CHECK_EN.
- Defined: o_err also set when i_imm[31:11] (I, I_L, S, B) or i_imm[31:19] (U) are not all equal; the word is still emitted with truncated fields.
- Undefined: o_err is set only for an unknown opcode.

Verification
REQ-030 SHALL check: `OP_I_TYPE, rd=1, rs1=2, funct3=0, imm=32'hFFFFFFFF -> o_instruction=32'hFFF10093, o_err=0, o_addr=0.
REQ-031 SHALL check: `OP_S_TYPE, rs1=6, rs2=5, funct3=2, imm=8 -> 32'h00532423 at o_addr=4.
REQ-032 SHALL check: `OP_LUI, rd=3, imm=32'h00012345 -> 32'h123451B7; round-trip through the immediate generator returns 32'h00012345.
REQ-033 SHALL check backpressure: two requests with i_ready=0 for 3 cycles -> first word stable, o_ready=0, second accepted only after i_ready=1, addresses 0 then 4.
REQ-034 SHALL check: `OP_I_TYPE, imm=32'h00000800 -> with IMM_RANGE_CHECK_EN: o_err=1, o_err_cnt=1; without: o_err=0; imm field [31:20]=12'h800 in both builds.
REQ-035 SHALL check: i_rst_n low while o_valid=1 and o_err_cnt=5 -> o_valid, o_addr and o_err_cnt are 0 immediately; the next word gets o_addr=0.
